lcd_frame_scheduler: RTL and testbench

- Sequences the shared lcd_write byte engine after LCD init completes.
- Per frame it issues the address window: CASET (0x2A) with 4 bytes, then RASET (0x2B) with 4 bytes, then RAMWR (0x2C).
- It then streams H_RES*V_RES pixels, fetched from a pixel source (image ROM path) through a request/valid handshake.
- Image-select changes are latched only at frame boundaries, so a frame never mixes two images.

---
 rtl/lcd_frame_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_lcd_frame_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_frame_scheduler
//  Description : Drives the shared lcd_write byte engine once LCD init has
//                completed. Each frame sends the address window (CASET and
//                RASET, four bytes each) and RAMWR, then streams
//                H_RES*V_RES pixels. Pixels are fetched from a pixel source
//                through a pix_req / pix_valid handshake. An image-select
//                request only takes effect at the next RAMWR, so a frame
//                never mixes two images.
//
//  Ports       : clk_25MHz   - system clock
//                rst         - asynchronous active-high reset
//                init_done   - level, LCD init finished (low aborts a frame)
//                frame_go    - pulse, start one frame when CONTINUOUS = 0
//                img_sel     - requested image id
//                img_sel_req - pulse, latch img_sel as the pending image
//                image_id    - image id used by the current frame
//                wr_data     - {dc, byte}, dc = 0 command, dc = 1 data
//                wr_en       - byte valid towards lcd_write
//                wr_done     - pulse, byte consumed by lcd_write
//                pix_req     - single-cycle pixel fetch request
//                pix_x/pix_y - coordinate of the requested pixel
//                pix_data    - pixel value (RGB332 in [7:0], RGB565 in [15:0])
//                pix_valid   - pix_data valid
//                busy        - high from window command until frame end
//                frame_done  - pulse after the last pixel byte is consumed
//                frame_cnt   - completed frames, wraps at 2^16
//
//  Build option: LCD_SCHED_RGB565_EN - when defined, each pixel is sent as
//                two bytes (pix_data[15:8] then pix_data[7:0]).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_scheduler #(
    parameter int H_RES      = 240,
    parameter int V_RES      = 160,
    parameter int X_OFS      = 0,
    parameter int Y_OFS      = 0,
    parameter int CONTINUOUS = 1
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        init_done,
    input  logic        frame_go,
    input  logic [2:0]  img_sel,
    input  logic        img_sel_req,
    output logic [2:0]  image_id,
    output logic [8:0]  wr_data,
    output logic        wr_en,
    input  logic        wr_done,
    output logic        pix_req,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_win_cmd   = 4'd1;
    localparam logic [3:0] c_st_win_data  = 4'd2;
    localparam logic [3:0] c_st_ramwr     = 4'd3;
    localparam logic [3:0] c_st_fetch     = 4'd4;
    localparam logic [3:0] c_st_wait_pix  = 4'd5;
    localparam logic [3:0] c_st_send      = 4'd6;
    localparam logic [3:0] c_st_frame_end = 4'd7;
    localparam logic [3:0] c_st_hold      = 4'd8;

    // ------------------------------------------------------------------------
    // Window geometry and command bytes
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_xs = 16'(X_OFS);
    localparam logic [15:0] c_xe = 16'(X_OFS + H_RES - 1);
    localparam logic [15:0] c_ys = 16'(Y_OFS);
    localparam logic [15:0] c_ye = 16'(Y_OFS + V_RES - 1);

    localparam logic [8:0] c_x_last = 9'(H_RES - 1);
    localparam logic [7:0] c_y_last = 8'(V_RES - 1);

    localparam logic [8:0] c_cmd_caset = 9'h02A;
    localparam logic [8:0] c_cmd_raset = 9'h02B;
    localparam logic [8:0] c_cmd_ramwr = 9'h02C;

    // Byte index 0..3 walks the column window, 4..7 the row window.
    function automatic logic [8:0] win_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    win_byte = {1'b1, c_xs[15:8]};
            3'd1:    win_byte = {1'b1, c_xs[7:0]};
            3'd2:    win_byte = {1'b1, c_xe[15:8]};
            3'd3:    win_byte = {1'b1, c_xe[7:0]};
            3'd4:    win_byte = {1'b1, c_ys[15:8]};
            3'd5:    win_byte = {1'b1, c_ys[7:0]};
            3'd6:    win_byte = {1'b1, c_ye[15:8]};
            default: win_byte = {1'b1, c_ye[7:0]};
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [3:0] r_state;
    logic [2:0] r_byte_idx;
    logic       r_pend_vld;
    logic [2:0] r_pend_id;

    logic       w_take;
    logic       w_px_done;
    logic [2:0] w_idx_next;

    // A wr_done only counts while a byte is actually being presented.
    assign w_take     = wr_en & wr_done;
    assign w_idx_next = r_byte_idx + 3'd1;

`ifdef LCD_SCHED_RGB565_EN
    logic       r_lo_half;
    logic [7:0] r_pix_lo;

    // The coordinate only advances once the low byte has gone out.
    assign w_px_done = r_lo_half;
`else
    logic w_unused_pix_hi;

    assign w_px_done       = 1'b1;
    assign w_unused_pix_hi = ^pix_data[15:8];
`endif

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_byte_idx <= 3'd0;
            r_pend_vld <= 1'b0;
            r_pend_id  <= 3'd0;
            image_id   <= 3'd0;
            wr_data    <= 9'h000;
            wr_en      <= 1'b0;
            pix_req    <= 1'b0;
            pix_x      <= 9'd0;
            pix_y      <= 8'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
`ifdef LCD_SCHED_RGB565_EN
            r_lo_half  <= 1'b0;
            r_pix_lo   <= 8'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            pix_req    <= 1'b0;

            if (!init_done && (r_state != c_st_idle)) begin
                // Panel lost: drop the handshake, restart the next frame at
                // pixel (0,0); image_id and frame_cnt are left untouched.
                r_state    <= c_st_idle;
                r_byte_idx <= 3'd0;
                wr_en      <= 1'b0;
                busy       <= 1'b0;
                pix_x      <= 9'd0;
                pix_y      <= 8'd0;
`ifdef LCD_SCHED_RGB565_EN
                r_lo_half  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (init_done) begin
                            r_state    <= c_st_win_cmd;
                            r_byte_idx <= 3'd0;
                            wr_en      <= 1'b1;
                            wr_data    <= c_cmd_caset;
                            busy       <= 1'b1;
                        end
                    end

                    c_st_win_cmd: begin
                        if (w_take) begin
                            r_state <= c_st_win_data;
                            wr_data <= win_byte(r_byte_idx);
                        end
                    end

                    c_st_win_data: begin
                        if (w_take) begin
                            if (r_byte_idx == 3'd3) begin
                                r_byte_idx <= 3'd4;
                                r_state    <= c_st_win_cmd;
                                wr_data    <= c_cmd_raset;
                            end else if (r_byte_idx == 3'd7) begin
                                r_state <= c_st_ramwr;
                                wr_data <= c_cmd_ramwr;
                            end else begin
                                r_byte_idx <= w_idx_next;
                                wr_data    <= win_byte(w_idx_next);
                            end
                        end
                    end

                    c_st_ramwr: begin
                        if (w_take) begin
                            wr_en   <= 1'b0;
                            r_state <= c_st_fetch;
                            pix_req <= 1'b1;
                            if (r_pend_vld) begin
                                image_id   <= r_pend_id;
                                r_pend_vld <= 1'b0;
                            end
                        end
                    end

                    // pix_req was raised on entry; it is high for exactly
                    // this cycle.
                    c_st_fetch: begin
                        r_state <= c_st_wait_pix;
                    end

                    c_st_wait_pix: begin
                        if (pix_valid) begin
                            r_state <= c_st_send;
                            wr_en   <= 1'b1;
`ifdef LCD_SCHED_RGB565_EN
                            r_pix_lo  <= pix_data[7:0];
                            r_lo_half <= 1'b0;
                            wr_data   <= {1'b1, pix_data[15:8]};
`else
                            wr_data   <= {1'b1, pix_data[7:0]};
`endif
                        end
                    end

                    c_st_send: begin
                        if (w_take) begin
                            if (w_px_done) begin
                                wr_en <= 1'b0;
                                if (pix_x == c_x_last) begin
                                    pix_x <= 9'd0;
                                    if (pix_y == c_y_last) begin
                                        r_state    <= c_st_frame_end;
                                        frame_done <= 1'b1;
                                        frame_cnt  <= frame_cnt + 16'd1;
                                    end else begin
                                        pix_y   <= pix_y + 8'd1;
                                        r_state <= c_st_fetch;
                                        pix_req <= 1'b1;
                                    end
                                end else begin
                                    pix_x   <= pix_x + 9'd1;
                                    r_state <= c_st_fetch;
                                    pix_req <= 1'b1;
                                end
                            end
`ifdef LCD_SCHED_RGB565_EN
                            else begin
                                r_lo_half <= 1'b1;
                                wr_data   <= {1'b1, r_pix_lo};
                            end
`endif
                        end
                    end

                    c_st_frame_end: begin
                        pix_x <= 9'd0;
                        pix_y <= 8'd0;
                        if (CONTINUOUS != 0) begin
                            r_state    <= c_st_win_cmd;
                            r_byte_idx <= 3'd0;
                            wr_en      <= 1'b1;
                            wr_data    <= c_cmd_caset;
                        end else begin
                            r_state <= c_st_hold;
                            busy    <= 1'b0;
                        end
                    end

                    c_st_hold: begin
                        if (frame_go) begin
                            r_state    <= c_st_win_cmd;
                            r_byte_idx <= 3'd0;
                            wr_en      <= 1'b1;
                            wr_data    <= c_cmd_caset;
                            busy       <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= c_st_idle;
                        wr_en   <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end

            // Placed last so a request landing on the RAMWR latch cycle
            // becomes pending for the following frame.
            if (img_sel_req) begin
                r_pend_vld <= 1'b1;
                r_pend_id  <= img_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_frame_scheduler
//  Description : Self-checking bench for lcd_frame_scheduler. Two instances:
//                dut_a (continuous, zero offsets) and dut_b (frame_go driven,
//                non-zero offsets). Randomized wr_done and pix_valid latency;
//                expected byte streams come from a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_scheduler;

    localparam int TB_H = 8;
    localparam int TB_V = 4;
`ifdef LCD_SCHED_RGB565_EN
    localparam int BPP = 2;
`else
    localparam int BPP = 1;
`endif
    localparam int FRAME_LEN = 11 + BPP * TB_H * TB_V;
    localparam int B_XO = 300;
    localparam int B_YO = 2;
    localparam int LIMIT = 8000;

    logic clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    // ---------------- DUT A signals ----------------
    logic        rst_a, init_done_a, frame_go_a, img_sel_req_a;
    logic [2:0]  img_sel_a, image_id_a;
    logic [8:0]  wr_data_a, pix_x_a;
    logic        wr_en_a, wr_done_a, pix_req_a, pix_valid_a, busy_a, frame_done_a;
    logic [7:0]  pix_y_a;
    logic [15:0] pix_data_a, frame_cnt_a;

    // ---------------- DUT B signals ----------------
    logic        rst_b, init_done_b, frame_go_b, img_sel_req_b;
    logic [2:0]  img_sel_b, image_id_b;
    logic [8:0]  wr_data_b, pix_x_b;
    logic        wr_en_b, wr_done_b, pix_req_b, pix_valid_b, busy_b, frame_done_b;
    logic [7:0]  pix_y_b;
    logic [15:0] pix_data_b, frame_cnt_b;

    lcd_frame_scheduler #(.H_RES(TB_H), .V_RES(TB_V), .X_OFS(0), .Y_OFS(0), .CONTINUOUS(1)) dut_a (
        .clk_25MHz(clk_25MHz), .rst(rst_a), .init_done(init_done_a), .frame_go(frame_go_a),
        .img_sel(img_sel_a), .img_sel_req(img_sel_req_a), .image_id(image_id_a),
        .wr_data(wr_data_a), .wr_en(wr_en_a), .wr_done(wr_done_a),
        .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_data(pix_data_a),
        .pix_valid(pix_valid_a), .busy(busy_a), .frame_done(frame_done_a), .frame_cnt(frame_cnt_a)
    );

    lcd_frame_scheduler #(.H_RES(TB_H), .V_RES(TB_V), .X_OFS(B_XO), .Y_OFS(B_YO), .CONTINUOUS(0)) dut_b (
        .clk_25MHz(clk_25MHz), .rst(rst_b), .init_done(init_done_b), .frame_go(frame_go_b),
        .img_sel(img_sel_b), .img_sel_req(img_sel_req_b), .image_id(image_id_b),
        .wr_data(wr_data_b), .wr_en(wr_en_b), .wr_done(wr_done_b),
        .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_data(pix_data_b),
        .pix_valid(pix_valid_b), .busy(busy_b), .frame_done(frame_done_b), .frame_cnt(frame_cnt_b)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] pix_mem [TB_H*TB_V];

    function automatic logic [15:0] pix_lookup(input logic [8:0] x, input logic [7:0] y);
        if (int'(x) < TB_H && int'(y) < TB_V) return pix_mem[int'(y) * TB_H + int'(x)];
        return 16'hDEAD;
    endfunction

    // Byte k of a frame: 11 window/command bytes, then pixels in raster order.
    function automatic logic [8:0] exp_byte(input int k, input int xo, input int yo);
        logic [15:0] xs, xe, ys, ye, px;
        int p;
        xs = 16'(xo);
        xe = 16'(xo + TB_H - 1);
        ys = 16'(yo);
        ye = 16'(yo + TB_V - 1);
        case (k)
            0:  return 9'h02A;
            1:  return {1'b1, xs[15:8]};
            2:  return {1'b1, xs[7:0]};
            3:  return {1'b1, xe[15:8]};
            4:  return {1'b1, xe[7:0]};
            5:  return 9'h02B;
            6:  return {1'b1, ys[15:8]};
            7:  return {1'b1, ys[7:0]};
            8:  return {1'b1, ye[15:8]};
            9:  return {1'b1, ye[7:0]};
            10: return 9'h02C;
            default: begin
                p  = (k - 11) / BPP;
                px = pix_mem[p];
                if (BPP == 2 && ((k - 11) % BPP) == 0) return {1'b1, px[15:8]};
                return {1'b1, px[7:0]};
            end
        endcase
    endfunction

    // Model state for DUT A
    int         a_k = 0, a_frames = 0, a_cnt = 0, a_dly = 2;
    logic [8:0] a_first = '0;
    logic [2:0] m_image = 3'd0, m_pend = 3'd0;
    logic       m_pend_v = 1'b0;
    logic       a_done_due = 1'b0;
    int         a_req_seq = 0, a_req_served = 0;
    logic [2:0] a_req_val = 3'd0;
    logic       a_req_coinc = 1'b0;

    // Byte sink / scoreboard for DUT A
    initial begin
        logic cur_due, ramwr, fire;
        wr_done_a = 1'b0; img_sel_req_a = 1'b0; img_sel_a = 3'd0;
        forever begin
            @(negedge clk_25MHz);
            cur_due = a_done_due;
            a_done_due = 1'b0;
            wr_done_a = 1'b0;
            img_sel_req_a = 1'b0;
            ramwr = 1'b0;
            fire = 1'b0;
            if (rst_a) begin
                a_k = 0; a_cnt = 0; a_frames = 0;
                m_image = 3'd0; m_pend_v = 1'b0;
            end else if (!init_done_a) begin
                a_k = 0; a_cnt = 0;
            end else begin
                if (frame_done_a || cur_due) begin
                    check_val("a_frame_done", 32'(frame_done_a), 32'(cur_due));
                    check_val("a_frame_cnt", 32'(frame_cnt_a), 32'(a_frames[15:0]));
                end
                if (wr_en_a) begin
                    if (a_cnt == 0) a_first = wr_data_a;
                    a_cnt++;
                    if (a_cnt >= a_dly) begin
                        wr_done_a = 1'b1;
                        check_val("a_byte", 32'(wr_data_a), 32'(exp_byte(a_k, 0, 0)));
                        check_val("a_stable", 32'(wr_data_a), 32'(a_first));
                        check_val("a_image_id", 32'(image_id_a), 32'(m_image));
                        ramwr = (a_k == 10);
                        a_k++;
                        if (a_k == FRAME_LEN) begin
                            a_k = 0;
                            a_frames++;
                            a_done_due = 1'b1;
                        end
                        a_cnt = 0;
                        a_dly = $urandom_range(1, 4);
                    end
                end else begin
                    a_cnt = 0;
                    if ($urandom_range(0, 7) == 0) wr_done_a = 1'b1;
                end
                if (a_req_served != a_req_seq && (!a_req_coinc || ramwr)) begin
                    img_sel_a = a_req_val;
                    img_sel_req_a = 1'b1;
                    a_req_served = a_req_seq;
                    fire = 1'b1;
                end
                if (ramwr && m_pend_v) begin
                    m_image = m_pend;
                    m_pend_v = 1'b0;
                end
                if (fire) begin
                    m_pend = a_req_val;
                    m_pend_v = 1'b1;
                end
            end
        end
    end

    // Pixel source for DUT A (1..3 cycle latency, occasional stray valid)
    initial begin
        int a_pdue;
        logic [15:0] a_pval;
        a_pdue = 0; a_pval = '0;
        pix_valid_a = 1'b0; pix_data_a = '0;
        forever begin
            @(negedge clk_25MHz);
            pix_valid_a = 1'b0;
            if (a_pdue > 0) begin
                a_pdue--;
                if (a_pdue == 0) begin
                    pix_valid_a = 1'b1;
                    pix_data_a = a_pval;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                pix_valid_a = 1'b1;
                pix_data_a = 16'($urandom);
            end
            if (pix_req_a && !rst_a) begin
                a_pval = pix_lookup(pix_x_a, pix_y_a);
                a_pdue = $urandom_range(1, 3);
            end
        end
    end

    // Byte sink and pixel source for DUT B
    int b_k = 0, b_frames = 0, b_cnt = 0;
    initial begin
        logic b_due;
        logic [15:0] b_val;
        b_due = 1'b0; b_val = '0;
        wr_done_b = 1'b0; pix_valid_b = 1'b0; pix_data_b = '0;
        forever begin
            @(negedge clk_25MHz);
            wr_done_b = 1'b0;
            pix_valid_b = 1'b0;
            if (rst_b) begin
                b_k = 0; b_cnt = 0; b_frames = 0;
            end else if (wr_en_b) begin
                b_cnt++;
                if (b_cnt >= 2) begin
                    wr_done_b = 1'b1;
                    check_val("b_byte", 32'(wr_data_b), 32'(exp_byte(b_k, B_XO, B_YO)));
                    b_k++;
                    if (b_k == FRAME_LEN) begin
                        b_k = 0;
                        b_frames++;
                    end
                    b_cnt = 0;
                end
            end else begin
                b_cnt = 0;
            end
            if (b_due) begin
                pix_valid_b = 1'b1;
                pix_data_b = b_val;
                b_due = 1'b0;
            end
            if (pix_req_b && !rst_b) begin
                b_val = pix_lookup(pix_x_b, pix_y_b);
                b_due = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_frames_a(input int n);
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk_25MHz);
            if (a_frames >= n) break;
        end
    endtask

    task automatic wait_k_a(input int kk);
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk_25MHz);
            if (a_k >= kk) break;
        end
    endtask

    task automatic request_img_a(input logic [2:0] v, input logic coinc);
        a_req_val = v;
        a_req_coinc = coinc;
        a_req_seq++;
    endtask

    task automatic check_reset_a(input string tag);
        check_val({tag, "_wr_en"},      32'(wr_en_a),      32'h0);
        check_val({tag, "_wr_data"},    32'(wr_data_a),    32'h0);
        check_val({tag, "_pix_req"},    32'(pix_req_a),    32'h0);
        check_val({tag, "_pix_x"},      32'(pix_x_a),      32'h0);
        check_val({tag, "_pix_y"},      32'(pix_y_a),      32'h0);
        check_val({tag, "_image_id"},   32'(image_id_a),   32'h0);
        check_val({tag, "_busy"},       32'(busy_a),       32'h0);
        check_val({tag, "_frame_done"}, 32'(frame_done_a), 32'h0);
        check_val({tag, "_frame_cnt"},  32'(frame_cnt_a),  32'h0);
    endtask

    // ---------------- DUT A sequence ----------------
    task automatic run_a();
        int fr;
        repeat (3) @(posedge clk_25MHz);
        #1 check_reset_a("a_rst");
        @(posedge clk_25MHz); #5;
        rst_a = 1'b0;
        init_done_a = 1'b1;

        wait_frames_a(1);
        repeat (2) @(negedge clk_25MHz);
        check_val("a_frames1", 32'(frame_cnt_a), 32'd1);
        check_val("a_busy_cont", 32'(busy_a), 32'd1);

        // Request mid-frame: takes effect only at the next RAMWR.
        wait_k_a(20);
        request_img_a(3'd3, 1'b0);
        repeat (6) @(negedge clk_25MHz);
        check_val("a_img_hold_now", 32'(image_id_a), 32'd0);
        wait_frames_a(2);
        check_val("a_img_hold_end", 32'(image_id_a), 32'd0);
        wait_k_a(12);
        check_val("a_img_3", 32'(image_id_a), 32'd3);

        // Two requests in one frame: latest wins.
        wait_k_a(15);
        request_img_a(3'd2, 1'b0);
        repeat (20) @(negedge clk_25MHz);
        request_img_a(3'd4, 1'b0);
        wait_frames_a(3);
        wait_k_a(12);
        check_val("a_img_4", 32'(image_id_a), 32'd4);

        // Request coinciding with the RAMWR latch goes to the frame after.
        request_img_a(3'd6, 1'b1);
        wait_frames_a(4);
        wait_k_a(12);
        check_val("a_img_coinc_hold", 32'(image_id_a), 32'd4);
        wait_frames_a(5);
        a_req_coinc = 1'b0;
        wait_k_a(12);
        check_val("a_img_6", 32'(image_id_a), 32'd6);

        // init_done drop at pixel 10.
        wait_k_a(11 + 10 * BPP);
        fr = a_frames;
        @(posedge clk_25MHz); #5;
        init_done_a = 1'b0;
        @(posedge clk_25MHz); #1;
        check_val("a_abort_wr_en", 32'(wr_en_a), 32'd0);
        check_val("a_abort_pix_req", 32'(pix_req_a), 32'd0);
        check_val("a_abort_busy", 32'(busy_a), 32'd0);
        check_val("a_abort_cnt", 32'(frame_cnt_a), 32'(fr));
        check_val("a_abort_img", 32'(image_id_a), 32'd6);
        repeat (5) @(posedge clk_25MHz);
        #1 check_val("a_idle_wr_en", 32'(wr_en_a), 32'd0);
        #4 init_done_a = 1'b1;
        wait_frames_a(fr + 1);
        repeat (2) @(negedge clk_25MHz);
        check_val("a_restart_cnt", 32'(frame_cnt_a), 32'(fr + 1));

        // Asynchronous reset mid-frame.
        wait_k_a(15);
        @(posedge clk_25MHz); #10;
        rst_a = 1'b1;
        #1 check_reset_a("a_async");
        @(posedge clk_25MHz); #5;
        rst_a = 1'b0;
        wait_frames_a(1);
        repeat (2) @(negedge clk_25MHz);
        check_val("a_post_rst_cnt", 32'(frame_cnt_a), 32'd1);
        check_val("a_post_rst_img", 32'(image_id_a), 32'd0);
    endtask

    // ---------------- DUT B sequence ----------------
    task automatic run_b();
        logic en_seen;
        repeat (3) @(posedge clk_25MHz);
        #1;
        check_val("b_rst_wr_en", 32'(wr_en_b), 32'd0);
        check_val("b_rst_busy", 32'(busy_b), 32'd0);
        check_val("b_rst_cnt", 32'(frame_cnt_b), 32'd0);
        @(posedge clk_25MHz); #5;
        rst_b = 1'b0;
        init_done_b = 1'b1;

        // frame_go while busy must be ignored.
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk_25MHz);
            if (b_k >= 5) break;
        end
        @(posedge clk_25MHz); #5 frame_go_b = 1'b1;
        @(posedge clk_25MHz); #5 frame_go_b = 1'b0;

        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk_25MHz);
            if (b_frames >= 1) break;
        end
        repeat (3) @(negedge clk_25MHz);
        check_val("b_frames1", 32'(frame_cnt_b), 32'd1);
        check_val("b_hold_busy", 32'(busy_b), 32'd0);
        en_seen = 1'b0;
        repeat (60) begin
            @(negedge clk_25MHz);
            en_seen = en_seen | wr_en_b;
        end
        check_val("b_hold_wr_en", 32'(en_seen), 32'd0);
        check_val("b_hold_cnt", 32'(frame_cnt_b), 32'd1);

        @(posedge clk_25MHz); #5 frame_go_b = 1'b1;
        @(posedge clk_25MHz); #5 frame_go_b = 1'b0;
        #20 check_val("b_go_wr_en", 32'(wr_en_b), 32'd1);
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk_25MHz);
            if (b_frames >= 2) break;
        end
        repeat (3) @(negedge clk_25MHz);
        check_val("b_frames2", 32'(frame_cnt_b), 32'd2);
        check_val("b_hold2_busy", 32'(busy_b), 32'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        for (int i = 0; i < TB_H * TB_V; i++) pix_mem[i] = 16'($urandom);
        rst_a = 1'b1; init_done_a = 1'b0; frame_go_a = 1'b0;
        rst_b = 1'b1; init_done_b = 1'b0; frame_go_b = 1'b0;
        img_sel_b = 3'd0; img_sel_req_b = 1'b0;
        fork
            run_a();
            run_b();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
